// File: rtl/title_pkg.sv
// Shared definitions for the title-screen reveal controller.
// State encodings, default sprite geometry and the blanking colour.
package title_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WIPE  = 2'd1,
        S_BLINK = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    localparam int IMG_W_DEF = 584;
    localparam int IMG_H_DEF = 64;
    localparam logic [11:0] BLANK_COLOR = 12'h000;

endpackage

// File: rtl/title_anim_fsm.sv
// Frame-based animation sequencer: wipe reveal, blink, then steady show.
// All state advances on frame_tick; start restarts from any state.
module title_anim_fsm
    import title_pkg::*;
#(
    parameter int IMG_W        = IMG_W_DEF,
    parameter int WIPE_STEP    = 8,
    parameter int BLINK_FRAMES = 15,
    parameter int BLINK_COUNT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    output logic [9:0] reveal_col,
    output logic       visible,
    output logic       busy,
    output logic       done,
    output logic       idle
);

    state_t      state, state_n;
    logic [9:0]  reveal_n;
    logic        vis_n;
    logic [7:0]  frame_cnt, frame_n;
    logic [7:0]  toggle_cnt, toggle_n;
    logic        done_n;
    logic [10:0] sum;

    always_comb begin
        state_n  = state;
        reveal_n = reveal_col;
        vis_n    = visible;
        frame_n  = frame_cnt;
        toggle_n = toggle_cnt;
        done_n   = 1'b0;
        sum      = 11'(reveal_col) + 11'(WIPE_STEP);
        // start has priority over a coincident frame_tick
        if (start) begin
            state_n  = S_WIPE;
            reveal_n = '0;
            vis_n    = 1'b1;
            frame_n  = '0;
            toggle_n = '0;
        end else if (frame_tick) begin
            case (state)
                S_WIPE: begin
                    if (sum >= 11'(IMG_W)) begin
                        reveal_n = 10'(IMG_W);
                        state_n  = S_BLINK;
                        frame_n  = '0;
                        toggle_n = '0;
                    end else begin
                        reveal_n = sum[9:0];
                    end
                end
                S_BLINK: begin
                    if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                        frame_n  = '0;
                        vis_n    = ~visible;
                        toggle_n = toggle_cnt + 8'd1;
                        if (toggle_n == 8'(2 * BLINK_COUNT)) begin
                            state_n = S_SHOW;
                            done_n  = 1'b1;
                        end
                    end else begin
                        frame_n = frame_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            reveal_col <= '0;
            visible    <= 1'b1;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            reveal_col <= reveal_n;
            visible    <= vis_n;
            frame_cnt  <= frame_n;
            toggle_cnt <= toggle_n;
            done       <= done_n;
        end
    end

    assign busy = (state == S_WIPE) || (state == S_BLINK);
    assign idle = (state == S_IDLE);

endmodule

// File: rtl/title_reveal_ctrl.sv
// Title window address generator and 3-stage recolour pipe around the
// external fill ROM; animation sequencing lives in title_anim_fsm.
module title_reveal_ctrl
    import title_pkg::*;
#(
    parameter int          X0           = 28,
    parameter int          Y0           = 100,
    parameter int          IMG_W        = IMG_W_DEF,
    parameter int          IMG_H        = IMG_H_DEF,
    parameter int          WIPE_STEP    = 8,
    parameter int          BLINK_FRAMES = 15,
    parameter int          BLINK_COUNT  = 3,
    parameter logic [11:0] FILL_COLOR   = 12'hFC0,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [7:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] fill_data,
    output logic [11:0] pixel_color,
    output logic        busy,
    output logic        done
);

    logic [9:0]  reveal_col;
    logic        visible;
    logic        idle;
    logic [10:0] xw, yw;
    logic        in_win;
    logic [7:0]  row_off;
    logic [9:0]  col_off;
    logic        shown;
    logic        shown1, von1;
    logic        shown2, von2;

    title_anim_fsm #(
        .IMG_W        (IMG_W),
        .WIPE_STEP    (WIPE_STEP),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_COUNT  (BLINK_COUNT)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .reveal_col (reveal_col),
        .visible    (visible),
        .busy       (busy),
        .done       (done),
        .idle       (idle)
    );

    assign xw      = {1'b0, x};
    assign yw      = {1'b0, y};
    assign in_win  = video_on
                  && xw >= 11'(X0) && xw < 11'(X0 + IMG_W)
                  && yw >= 11'(Y0) && yw < 11'(Y0 + IMG_H);
    assign row_off = 8'(y - 10'(Y0));
    assign col_off = x - 10'(X0);
    // Reveal compare uses the column before it is registered
    assign shown   = in_win && (col_off < reveal_col) && visible && !idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_row     <= '0;
            rom_col     <= '0;
            shown1      <= 1'b0;
            von1        <= 1'b0;
            shown2      <= 1'b0;
            von2        <= 1'b0;
            pixel_color <= '0;
        end else begin
            rom_row <= in_win ? row_off : 8'd0;
            rom_col <= in_win ? col_off : 10'd0;
            shown1  <= shown;
            von1    <= video_on;
            shown2  <= shown1;
            von2    <= von1;
            if (!von2)
                pixel_color <= BLANK_COLOR;
            else if (shown2 && (fill_data != 12'd0))
                pixel_color <= FILL_COLOR;
            else
                pixel_color <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_title_reveal_ctrl.sv
// Directed self-checking bench for title_reveal_ctrl.
// A second instance with a wide wipe step exercises saturation.
module tb_title_reveal_ctrl;
    import title_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, frame_tick, video_on;
    logic [9:0]  x, y;
    logic [11:0] fill_data;
    logic [7:0]  rom_row, rom_row2;
    logic [9:0]  rom_col, rom_col2;
    logic [11:0] pixel_color, pixel_color2;
    logic        busy, done, busy2, done2;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_snap;

    always #5 clk = ~clk;

    title_reveal_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .rom_row(rom_row),
        .rom_col(rom_col), .fill_data(fill_data),
        .pixel_color(pixel_color), .busy(busy), .done(done)
    );

    title_reveal_ctrl #(.WIPE_STEP(100)) dut2 (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .rom_row(rom_row2),
        .rom_col(rom_col2), .fill_data(fill_data),
        .pixel_color(pixel_color2), .busy(busy2), .done(done2)
    );

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Apply a pixel and wait out the 3-cycle latency
    task automatic pix(input int px, input int py, input logic von,
                       input logic [11:0] fd);
        @(negedge clk);
        x = 10'(px); y = 10'(py); video_on = von; fill_data = fd;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        video_on = 1'b0; x = '0; y = '0; fill_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_pixel", 32'(pixel_color), 32'h0);
        chk("rst_row", 32'(rom_row), 32'h0);
        chk("rst_col", 32'(rom_col), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_state", 32'(dut.u_fsm.state), 32'(S_IDLE));
        reset = 1'b0;

        pix(100, 120, 1'b1, 12'hFFF);
        chk("idle_row", 32'(rom_row), 32'd20);
        chk("idle_col", 32'(rom_col), 32'd72);
        chk("idle_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("idle_pixel", 32'(pixel_color), 32'h000);
            @(negedge clk);
        end

        pulse_start();
        chk("start_state", 32'(dut.u_fsm.state), 32'(S_WIPE));
        chk("start_reveal", 32'(dut.u_fsm.reveal_col), 32'd0);
        chk("start_busy", 32'(busy), 32'h1);

        ticks(5);
        chk("wipe5_reveal", 32'(dut.u_fsm.reveal_col), 32'd40);
        chk("sat5_reveal", 32'(dut2.u_fsm.reveal_col), 32'd500);

        // x=100 (col 72) is not yet revealed; move to col 39 and time it
        pix(100, 120, 1'b1, 12'hFFF);
        chk("col72_hidden", 32'(pixel_color), 32'h000);
        @(negedge clk) x = 10'd67;
        repeat (2) @(negedge clk);
        chk("lat2_old", 32'(pixel_color), 32'h000);
        @(negedge clk);
        chk("lat3_fill", 32'(pixel_color), 32'hFC0);
        pix(68, 120, 1'b1, 12'hFFF);
        chk("col40_bg", 32'(pixel_color), 32'h000);
        pix(67, 120, 1'b1, 12'h000);
        chk("zero_rom_bg", 32'(pixel_color), 32'h000);

        ticks(1);
        chk("sat6_reveal", 32'(dut2.u_fsm.reveal_col), 32'd584);
        chk("sat6_state", 32'(dut2.u_fsm.state), 32'(S_BLINK));
        chk("wipe6_reveal", 32'(dut.u_fsm.reveal_col), 32'd48);

        ticks(66);
        chk("wipe72_reveal", 32'(dut.u_fsm.reveal_col), 32'd576);
        chk("wipe72_state", 32'(dut.u_fsm.state), 32'(S_WIPE));
        ticks(1);
        chk("wipe73_reveal", 32'(dut.u_fsm.reveal_col), 32'd584);
        chk("wipe73_state", 32'(dut.u_fsm.state), 32'(S_BLINK));
        chk("blink_busy", 32'(busy), 32'h1);

        pix(27, 120, 1'b1, 12'hFFF);
        chk("left_col", 32'(rom_col), 32'd0);
        chk("left_pix", 32'(pixel_color), 32'h000);
        pix(612, 120, 1'b1, 12'hFFF);
        chk("right_col", 32'(rom_col), 32'd0);
        chk("right_pix", 32'(pixel_color), 32'h000);
        pix(611, 163, 1'b1, 12'hFFF);
        chk("corner_row", 32'(rom_row), 32'd63);
        chk("corner_col", 32'(rom_col), 32'd583);
        chk("corner_pix", 32'(pixel_color), 32'hFC0);
        pix(611, 164, 1'b1, 12'hFFF);
        chk("below_row", 32'(rom_row), 32'd0);
        chk("below_pix", 32'(pixel_color), 32'h000);
        pix(67, 120, 1'b0, 12'hFFF);
        chk("blank_pix", 32'(pixel_color), 32'h000);

        ticks(14);
        chk("blink14_vis", 32'(dut.u_fsm.visible), 32'h1);
        ticks(1);
        chk("blink15_vis", 32'(dut.u_fsm.visible), 32'h0);
        pix(67, 120, 1'b1, 12'hFFF);
        chk("blink_off_pix", 32'(pixel_color), 32'h000);
        ticks(15);
        chk("blink30_vis", 32'(dut.u_fsm.visible), 32'h1);
        ticks(59);
        chk("blink89_state", 32'(dut.u_fsm.state), 32'(S_BLINK));
        chk("blink89_done", 32'(done_cnt), 32'd0);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        chk("show_state", 32'(dut.u_fsm.state), 32'(S_SHOW));
        chk("show_done", 32'(done), 32'h1);
        chk("show_busy", 32'(busy), 32'h0);
        chk("show_vis", 32'(dut.u_fsm.visible), 32'h1);
        @(negedge clk);
        chk("done_drop", 32'(done), 32'h0);
        ticks(3);
        chk("done_once", 32'(done_cnt), 32'd1);
        pix(67, 120, 1'b1, 12'hFFF);
        chk("show_pix", 32'(pixel_color), 32'hFC0);

        pulse_start();
        ticks(73);
        ticks(20);
        chk("coll_pre_vis", 32'(dut.u_fsm.visible), 32'h0);
        @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
        chk("coll_state", 32'(dut.u_fsm.state), 32'(S_WIPE));
        chk("coll_reveal", 32'(dut.u_fsm.reveal_col), 32'd0);
        chk("coll_vis", 32'(dut.u_fsm.visible), 32'h1);

        ticks(3);
        pix(30, 120, 1'b1, 12'hFFF);
        chk("prerst_pix", 32'(pixel_color), 32'hFC0);
        done_snap = done_cnt;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("rst_mid_pix", 32'(pixel_color), 32'h0);
        chk("rst_mid_state", 32'(dut.u_fsm.state), 32'(S_IDLE));
        chk("rst_mid_busy", 32'(busy), 32'h0);
        ticks(4);
        pix(30, 120, 1'b1, 12'hFFF);
        chk("post_rst_pix", 32'(pixel_color), 32'h000);
        chk("post_rst_state", 32'(dut.u_fsm.state), 32'(S_IDLE));
        chk("post_rst_done", 32'(done_cnt - done_snap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
